// File: rtl/dcache_flush_sequencer.sv
// Write-back dcache flush walker: per set, read tags, write back dirty ways serially, invalidate valid ways.
// Optional perf counters (flush_cycles_o, wb_count_o) exist only when DCACHE_FLUSH_PERF_EN is defined.
module dcache_flush_sequencer #(
    parameter int CACHE_BYTES = 4096,
    parameter int LINE_WIDTH  = 128,
    parameter int SET_ASSOC   = 8,
    parameter int NUM_SETS    = CACHE_BYTES / (LINE_WIDTH / 8) / SET_ASSOC,
    parameter int IDX_W       = $clog2(NUM_SETS),
    parameter int WAY_W       = $clog2(SET_ASSOC)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 flush_ack_o,
    output logic                 tag_req_o,
    input  logic                 tag_gnt_i,
    output logic [IDX_W-1:0]     tag_idx_o,
    input  logic                 tag_rvalid_i,
    input  logic [SET_ASSOC-1:0] valid_i,
    input  logic [SET_ASSOC-1:0] dirty_i,
    output logic                 wb_req_o,
    input  logic                 wb_gnt_i,
    output logic [IDX_W-1:0]     wb_idx_o,
    output logic [WAY_W-1:0]     wb_way_o,
    input  logic                 wb_done_i,
    output logic                 inv_req_o,
    input  logic                 inv_gnt_i,
    output logic [IDX_W-1:0]     inv_idx_o,
    output logic [SET_ASSOC-1:0] inv_mask_o,
    output logic [2:0]           dbg_state_o
`ifdef DCACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]          flush_cycles_o,
    output logic [15:0]          wb_count_o
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TAG_REQ  = 3'd1;
    localparam logic [2:0] S_TAG_WAIT = 3'd2;
    localparam logic [2:0] S_WB_REQ   = 3'd3;
    localparam logic [2:0] S_WB_WAIT  = 3'd4;
    localparam logic [2:0] S_INV      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]           r_state;
    logic [IDX_W-1:0]     r_set;
    logic                 r_pending;
    logic [SET_ASSOC-1:0] r_dirty;
    logic [SET_ASSOC-1:0] r_inv;

    logic [WAY_W-1:0]     w_way;
    logic [SET_ASSOC-1:0] w_way_oh;
    logic [SET_ASSOC-1:0] w_dirty_rem;
    logic [SET_ASSOC-1:0] w_rd_dirty;
    logic                 w_last_set;
    logic                 w_restart;

    // Lowest pending dirty way; stays constant through WB_REQ since r_dirty only changes in WB_WAIT.
    always_comb begin
        w_way = '0;
        for (int i = SET_ASSOC - 1; i >= 0; i--) begin
            if (r_dirty[i]) w_way = WAY_W'(i);
        end
    end

    assign w_way_oh    = SET_ASSOC'(1) << w_way;
    assign w_dirty_rem = r_dirty & ~w_way_oh;
    assign w_rd_dirty  = valid_i & dirty_i;
    assign w_last_set  = (r_set == IDX_W'(NUM_SETS - 1));
    assign w_restart   = r_pending | flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_set     <= '0;
            r_pending <= 1'b0;
            r_dirty   <= '0;
            r_inv     <= '0;
        end else begin
            if (flush_i && r_state != S_IDLE) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_state <= S_TAG_REQ;
                        r_set   <= '0;
                    end
                end
                S_TAG_REQ: begin
                    if (tag_gnt_i) r_state <= S_TAG_WAIT;
                end
                S_TAG_WAIT: begin
                    if (tag_rvalid_i) begin
                        r_dirty <= w_rd_dirty;
                        r_inv   <= valid_i;
                        if (|w_rd_dirty) begin
                            r_state <= S_WB_REQ;
                        end else if (|valid_i) begin
                            r_state <= S_INV;
                        end else if (w_last_set) begin
                            r_state <= S_DONE;
                        end else begin
                            r_set   <= r_set + 1'b1;
                            r_state <= S_TAG_REQ;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (wb_gnt_i) r_state <= S_WB_WAIT;
                end
                S_WB_WAIT: begin
                    if (wb_done_i) begin
                        r_dirty <= w_dirty_rem;
                        r_state <= (|w_dirty_rem) ? S_WB_REQ : S_INV;
                    end
                end
                S_INV: begin
                    if (inv_gnt_i) begin
                        if (w_last_set) begin
                            r_state <= S_DONE;
                        end else begin
                            r_set   <= r_set + 1'b1;
                            r_state <= S_TAG_REQ;
                        end
                    end
                end
                S_DONE: begin
                    // Any request seen while busy (or in this cycle) collapses into one more full walk.
                    r_set     <= '0;
                    r_pending <= 1'b0;
                    r_state   <= w_restart ? S_TAG_REQ : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only flops; index/way/mask fields read zero whenever their request is low.
    assign busy_o      = (r_state != S_IDLE);
    assign flush_ack_o = (r_state == S_DONE);
    assign tag_req_o   = (r_state == S_TAG_REQ);
    assign tag_idx_o   = tag_req_o ? r_set : '0;
    assign wb_req_o    = (r_state == S_WB_REQ);
    assign wb_idx_o    = wb_req_o ? r_set : '0;
    assign wb_way_o    = wb_req_o ? w_way : '0;
    assign inv_req_o   = (r_state == S_INV);
    assign inv_idx_o   = inv_req_o ? r_set : '0;
    assign inv_mask_o  = inv_req_o ? r_inv : '0;
    assign dbg_state_o = r_state;

`ifdef DCACHE_FLUSH_PERF_EN
    logic        w_start;
    logic [31:0] r_flush_cycles;
    logic [15:0] r_wb_count;

    assign w_start = ((r_state == S_IDLE) && flush_i) || ((r_state == S_DONE) && w_restart);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_cycles <= '0;
            r_wb_count     <= '0;
        end else if (w_start) begin
            r_flush_cycles <= '0;
            r_wb_count     <= '0;
        end else begin
            if (busy_o && r_flush_cycles != '1) r_flush_cycles <= r_flush_cycles + 1'b1;
            if ((r_state == S_WB_WAIT) && wb_done_i && r_wb_count != '1) r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign flush_cycles_o = r_flush_cycles;
    assign wb_count_o     = r_wb_count;
`endif

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Randomized bench for dcache_flush_sequencer: a cache-array responder plus an event-list reference model.
module tb_dcache_flush_sequencer;
  localparam int NS = 32;
  localparam int WAYS = 8;
  localparam logic [3:0] EV_T = 4'd1;
  localparam logic [3:0] EV_W = 4'd2;
  localparam logic [3:0] EV_I = 4'd3;
  localparam logic [3:0] EV_A = 4'd4;

  // clock / reset and DUT signals
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  logic tag_gnt_i = 1'b0, tag_rvalid_i = 1'b0, wb_gnt_i = 1'b0, wb_done_i = 1'b0, inv_gnt_i = 1'b0;
  logic [7:0] valid_i = 8'd0, dirty_i = 8'd0;
  logic busy_o, flush_ack_o, tag_req_o, wb_req_o, inv_req_o;
  logic [4:0] tag_idx_o, wb_idx_o, inv_idx_o;
  logic [2:0] wb_way_o;
  logic [7:0] inv_mask_o;
  logic [2:0] dbg_state_o;
`ifdef DCACHE_FLUSH_PERF_EN
  logic [31:0] flush_cycles_o;
  logic [15:0] wb_count_o;
`endif

  dcache_flush_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .busy_o(busy_o), .flush_ack_o(flush_ack_o),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_idx_o(tag_idx_o), .tag_rvalid_i(tag_rvalid_i),
    .valid_i(valid_i), .dirty_i(dirty_i),
    .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i), .wb_idx_o(wb_idx_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
    .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i), .inv_idx_o(inv_idx_o), .inv_mask_o(inv_mask_o),
    .dbg_state_o(dbg_state_o)
`ifdef DCACHE_FLUSH_PERF_EN
    , .flush_cycles_o(flush_cycles_o), .wb_count_o(wb_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk_evt(input logic [3:0] t, input logic [7:0] idx,
                                         input logic [3:0] way, input logic [7:0] mask);
    return {t, idx, way, mask};
  endfunction

  task automatic observe(input logic [23:0] ev);
    if (exp_q.size() == 0) check_eq("unexpected_event", 32'(ev), 32'd0);
    else check_eq("event", 32'(ev), 32'(exp_q.pop_front()));
  endtask

  // cache array seen by the responder, and the model's own copy
  logic [7:0] mem_valid[NS], mem_dirty[NS];
  logic [7:0] m_valid[NS], m_dirty[NS];

  task automatic sync_model();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = mem_valid[s];
      m_dirty[s] = mem_dirty[s];
    end
  endtask

  task automatic clear_cache();
    for (int s = 0; s < NS; s++) begin
      mem_valid[s] = 8'd0;
      mem_dirty[s] = 8'd0;
    end
    sync_model();
  endtask

  task automatic random_cache();
    for (int s = 0; s < NS; s++) begin
      mem_valid[s] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      mem_dirty[s] = 8'($urandom);
    end
    sync_model();
  endtask

  // Reference: a walk visits every set in order; dirty valid ways are written back lowest first,
  // then the set's valid ways are invalidated; one ack closes the walk.
  task automatic model_walk(output int n_wb);
    n_wb = 0;
    for (int s = 0; s < NS; s++) begin
      exp_q.push_back(mk_evt(EV_T, 8'(s), 4'd0, 8'd0));
      for (int w = 0; w < WAYS; w++) begin
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_q.push_back(mk_evt(EV_W, 8'(s), 4'(w), 8'd0));
          n_wb++;
        end
      end
      if (m_valid[s] != 8'd0) exp_q.push_back(mk_evt(EV_I, 8'(s), 4'd0, m_valid[s]));
      m_valid[s] = 8'd0;
    end
    exp_q.push_back(mk_evt(EV_A, 8'd0, 4'd0, 8'd0));
  endtask

  // responder knobs and state
  int gnt_max = 0, rv_max = 0, done_max = 0;
  bit spurious_en = 0;
  int force_wb_idx = -1, force_wb_dly = 0, force_done_dly = -1;
  int t_hold = 0, t_dly = 0, w_hold = 0, w_dly = 0, i_hold = 0, i_dly = 0;
  bit tag_wait = 0, wb_wait = 0;
  int rv_cnt = 0, done_cnt = 0;
  logic [4:0] t_idx = 5'd0, t_prev = 5'd0, w_prev_idx = 5'd0, i_prev_idx = 5'd0;
  logic [2:0] w_prev_way = 3'd0;
  logic [7:0] i_prev_mask = 8'd0;
  int ack_total = 0, wb_grants = 0;

  // driver: cache arbiter / tag array / writeback unit, acting #1 after each edge
  initial begin
    forever begin
      @(posedge clk_i); #1;
      tag_gnt_i = 1'b0; tag_rvalid_i = 1'b0; wb_gnt_i = 1'b0; wb_done_i = 1'b0; inv_gnt_i = 1'b0;
      valid_i = 8'($urandom); dirty_i = 8'($urandom);
      if (!rst_ni) begin
        tag_wait = 0; wb_wait = 0; t_hold = 0; w_hold = 0; i_hold = 0;
      end else begin
        if (tag_wait) begin
          if (rv_cnt == 0) begin
            tag_rvalid_i = 1'b1; valid_i = mem_valid[t_idx]; dirty_i = mem_dirty[t_idx]; tag_wait = 0;
          end else rv_cnt--;
        end else if (spurious_en && $urandom_range(0, 7) == 0) tag_rvalid_i = 1'b1;
        if (wb_wait) begin
          if (done_cnt == 0) begin wb_done_i = 1'b1; wb_wait = 0; end
          else done_cnt--;
        end else if (spurious_en && $urandom_range(0, 7) == 0) wb_done_i = 1'b1;

        if (tag_req_o) begin
          if (t_hold == 0) begin t_dly = $urandom_range(0, gnt_max); t_prev = tag_idx_o; end
          else check_eq("tag_idx_stable", 32'(tag_idx_o), 32'(t_prev));
          if (t_hold >= t_dly) begin
            tag_gnt_i = 1'b1; t_idx = tag_idx_o; tag_wait = 1; t_hold = 0;
            rv_cnt = $urandom_range(0, rv_max);
            observe(mk_evt(EV_T, 8'(tag_idx_o), 4'd0, 8'd0));
          end else t_hold++;
        end
        if (wb_req_o) begin
          if (w_hold == 0) begin
            w_dly = (force_wb_idx == int'(wb_idx_o)) ? force_wb_dly : $urandom_range(0, gnt_max);
            w_prev_idx = wb_idx_o; w_prev_way = wb_way_o;
          end else begin
            check_eq("wb_idx_stable", 32'(wb_idx_o), 32'(w_prev_idx));
            check_eq("wb_way_stable", 32'(wb_way_o), 32'(w_prev_way));
          end
          check_eq("no_tag_req_during_wb", 32'(tag_req_o), 32'd0);
          if (w_hold >= w_dly) begin
            wb_gnt_i = 1'b1; wb_wait = 1; w_hold = 0; wb_grants++;
            done_cnt = (force_done_dly >= 0) ? force_done_dly : $urandom_range(0, done_max);
            observe(mk_evt(EV_W, 8'(wb_idx_o), 4'(wb_way_o), 8'd0));
          end else w_hold++;
        end
        if (inv_req_o) begin
          if (i_hold == 0) begin i_dly = $urandom_range(0, gnt_max); i_prev_idx = inv_idx_o; i_prev_mask = inv_mask_o; end
          else begin
            check_eq("inv_idx_stable", 32'(inv_idx_o), 32'(i_prev_idx));
            check_eq("inv_mask_stable", 32'(inv_mask_o), 32'(i_prev_mask));
          end
          if (i_hold >= i_dly) begin
            inv_gnt_i = 1'b1; i_hold = 0; mem_valid[inv_idx_o] = 8'd0;
            observe(mk_evt(EV_I, 8'(inv_idx_o), 4'd0, inv_mask_o));
          end else i_hold++;
        end
        if (flush_ack_o) begin
          ack_total++;
          observe(mk_evt(EV_A, 8'd0, 4'd0, 8'd0));
        end
      end
    end
  end

  // Pulse flush, then run until n_walks acks; extra flush pulses at cycles p1/p2.
  // ack_cyc counts edges from the one that samples flush_i; busy_cnt covers the last walk only.
  task automatic do_flush(input int n_walks, input int p1, input int p2, output int ack_cyc, output int busy_cnt);
    int acks, n;
    bit chk_restart;
    acks = 0; n = 0; busy_cnt = 0; ack_cyc = -1; chk_restart = 0; wb_grants = 0;
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0; n = 1;
    while (acks < n_walks && n < 20000) begin
      if (chk_restart) begin
        check_eq("restart_tag_req", 32'(tag_req_o), 32'd1);
        check_eq("restart_idx", 32'(tag_idx_o), 32'd0);
        chk_restart = 0;
      end
      flush_i = (n == p1 || n == p2);
      busy_cnt += int'(busy_o);
      if (flush_ack_o) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = n;
        if (acks < n_walks) begin busy_cnt = 0; chk_restart = 1; wb_grants = 0; end
      end
      if (acks < n_walks) begin @(posedge clk_i); #1; n++; end
    end
    flush_i = 1'b0;
    check_eq("ack_count", 32'(acks), 32'(n_walks));
  endtask

  task automatic post_walk(input int exp_wb, input int busy_cnt, input string tag);
    @(posedge clk_i); #1;
    check_eq({tag, "_ack_one_cycle"}, 32'(flush_ack_o), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_wb_grants"}, 32'(wb_grants), 32'(exp_wb));
`ifdef DCACHE_FLUSH_PERF_EN
    check_eq({tag, "_flush_cycles"}, flush_cycles_o, 32'(busy_cnt));
    check_eq({tag, "_wb_count"}, 32'(wb_count_o), 32'(exp_wb));
`else
    check_eq({tag, "_busy_seen"}, 32'(busy_cnt > 0), 32'd1);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_ack"}, 32'(flush_ack_o), 32'd0);
    check_eq({tag, "_tag_req"}, 32'(tag_req_o), 32'd0);
    check_eq({tag, "_tag_idx"}, 32'(tag_idx_o), 32'd0);
    check_eq({tag, "_wb_req"}, 32'(wb_req_o), 32'd0);
    check_eq({tag, "_wb_idx"}, 32'(wb_idx_o), 32'd0);
    check_eq({tag, "_wb_way"}, 32'(wb_way_o), 32'd0);
    check_eq({tag, "_inv_req"}, 32'(inv_req_o), 32'd0);
    check_eq({tag, "_inv_idx"}, 32'(inv_idx_o), 32'd0);
    check_eq({tag, "_inv_mask"}, 32'(inv_mask_o), 32'd0);
    check_eq({tag, "_state_idle"}, 32'(dbg_state_o), 32'd0);
`ifdef DCACHE_FLUSH_PERF_EN
    check_eq({tag, "_flush_cycles"}, flush_cycles_o, 32'd0);
    check_eq({tag, "_wb_count"}, 32'(wb_count_o), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int nwb, nwb2, ack_cyc, busy_cnt, n, acks_before;
    clear_cache();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i); rst_ni = 1'b1;

    // clean cache, zero-wait: 2 cycles per set plus DONE
    model_walk(nwb);
    do_flush(1, -1, -1, ack_cyc, busy_cnt);
    check_eq("clean_ack_cycle", 32'(ack_cyc), 32'd65);
    check_eq("clean_busy_cycles", 32'(busy_cnt), 32'd65);
    post_walk(nwb, busy_cnt, "clean");

    // one set, two dirty ways, one-cycle done latency
    clear_cache();
    mem_valid[5] = 8'hFF; mem_dirty[5] = 8'h81; sync_model();
    model_walk(nwb);
    do_flush(1, -1, -1, ack_cyc, busy_cnt);
    check_eq("set5_wb_total", 32'(nwb), 32'd2);
    post_walk(nwb, busy_cnt, "set5");

    // writeback grant withheld 10 cycles on set 2
    clear_cache();
    mem_valid[2] = 8'h0F; mem_dirty[2] = 8'h04; sync_model();
    force_wb_idx = 2; force_wb_dly = 10;
    model_walk(nwb);
    do_flush(1, -1, -1, ack_cyc, busy_cnt);
    post_walk(nwb, busy_cnt, "wb_stall");
    force_wb_idx = -1;

    // two flush pulses mid-walk collapse into exactly one extra walk
    random_cache();
    model_walk(nwb);
    model_walk(nwb2);
    do_flush(2, 10, 20, ack_cyc, busy_cnt);
    post_walk(nwb2, busy_cnt, "double");

    // random contents, random grant/data latencies, spurious rvalid/done pulses
    for (int it = 0; it < 4; it++) begin
      gnt_max = 3; rv_max = 2; done_max = 3; spurious_en = 1;
      random_cache();
      model_walk(nwb);
      do_flush(1, -1, -1, ack_cyc, busy_cnt);
      post_walk(nwb, busy_cnt, "rand");
    end

    // async reset while waiting for the set 9 writeback; pending request is lost
    gnt_max = 0; rv_max = 0; done_max = 0; spurious_en = 0; force_done_dly = 40;
    clear_cache();
    mem_valid[9] = 8'h01; mem_dirty[9] = 8'h01; sync_model();
    model_walk(nwb);
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    n = 0;
    while (!wb_wait && n < 2000) begin @(posedge clk_i); #1; n++; end
    check_eq("rst_reach_wb_wait", 32'(wb_wait), 32'd1);
    acks_before = ack_total;
    repeat (3) @(posedge clk_i);
    #3; rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    check_eq("rst_exp_remaining", 32'(exp_q.size()), 32'd24);
    exp_q.delete();
    repeat (4) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    force_done_dly = -1;
    repeat (4) @(posedge clk_i);
    #1;
    check_eq("rst_no_ack", 32'(ack_total), 32'(acks_before));
    check_eq("rst_pending_lost", 32'(busy_o), 32'd0);
    sync_model();
    model_walk(nwb);
    do_flush(1, -1, -1, ack_cyc, busy_cnt);
    check_eq("rst_rewalk_wb_total", 32'(nwb), 32'd1);
    post_walk(nwb, busy_cnt, "rewalk");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
